// File: rtl/ex_stage_pkg.sv
// Shared types for the rv32imc execute stage: ALU opcodes, stage bundles, MDU states.
// Latency: n/a (types only).
// Backpressure: n/a.
package ex_stage_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASS_B,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } AluControlType;

  localparam logic [2:0] FUNCT3_BYTE   = 3'b000;
  localparam logic [2:0] FUNCT3_HALF   = 3'b001;
  localparam logic [2:0] FUNCT3_WORD   = 3'b010;
  localparam logic [2:0] FUNCT3_BYTE_U = 3'b100;
  localparam logic [2:0] FUNCT3_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2
  } DestSelectType;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } MduStateType;

  typedef struct packed {
    AluControlType aluControl;
    logic          loadSignal;
    logic          storeSignal;
    logic [2:0]    loadStoreByteSelect;
    logic [31:0]   storeData;
    logic [31:0]   operandA;
    logic [31:0]   operandB;
    logic [4:0]    rdAddr;
    logic          rdWriteEn;
    DestSelectType destinationSelect;
    logic [31:0]   pc;
  } EXStageSignals;

  typedef struct packed {
    logic [31:0]   aluResult;
    logic          loadSignal;
    logic          storeSignal;
    logic [2:0]    loadStoreByteSelect;
    logic [31:0]   storeData;
    logic [4:0]    rdAddr;
    logic          rdWriteEn;
    DestSelectType destinationSelect;
    logic [31:0]   pc;
  } MEStageSignals;

  function automatic logic is_mdu_op(AluControlType op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle: instruction in, flush, registered result out, stall back.
// Latency: n/a (wiring only).
// Backpressure: exStall tells the master to hold EXControl; flush kills the op in EX.
// Ports: EXControl, flush (master -> slave); MEControl, exStall (slave -> master).
interface ex_stage_if;
  import ex_stage_pkg::*;

  EXStageSignals EXControl;
  logic          flush;
  MEStageSignals MEControl;
  logic          exStall;

  modport master (output EXControl, output flush, input MEControl, input exStall);
  modport slave  (input EXControl, input flush, output MEControl, output exStall);
endinterface

// File: rtl/ex_stage_mdu_iterative.sv
// Iterative M-extension unit: shift-add multiply / restoring divide, 1 bit per cycle.
// Latency: 34 edges for iterative ops (issue, 32 steps, done); fast-path ops are combinational.
// Backpressure: busy is high in the issue cycle and all step cycles; flush aborts and drops busy.
// Ports: clk, arstn, start (M op present), op, a, b, flush -> busy, done, result.
module ex_stage_mdu_iterative
  import ex_stage_pkg::*;
#(
  parameter bit ITERATIVE_MUL = 1'b1,
  parameter int STEPS         = 32
) (
  input  logic          clk,
  input  logic          arstn,
  input  logic          start,
  input  AluControlType op,
  input  logic [31:0]   a,
  input  logic [31:0]   b,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [31:0]   result
);

  MduStateType   state_q, state_d;
  logic [5:0]    count_q, count_d;
  logic [63:0]   acc_q, acc_d;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [31:0]   opnd_q, opnd_d;    // mul: |multiplicand|; div: |divisor|
  AluControlType op_q, op_d;
  logic          neg_a_q, neg_a_d, neg_b_q, neg_b_d;

  // Issue-time decode
  logic        is_mul, is_div, is_rem, signed_div, div_zero, div_ovf, comb_mul, fast;
  logic        sa_in, sb_in;
  logic [31:0] abs_a, abs_b, fast_result;
  logic [63:0] a64, b64, prod_comb;

  always_comb begin
    is_mul     = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    is_div     = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    is_rem     = op inside {ALU_REM, ALU_REMU};
    signed_div = op inside {ALU_DIV, ALU_REM};
    div_zero   = is_div && (b == 32'h0);
    div_ovf    = signed_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    comb_mul   = is_mul && !ITERATIVE_MUL;
    fast       = div_zero || div_ovf || comb_mul;

    sa_in = a[31] && (op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM});
    sb_in = b[31] && (op inside {ALU_MULH, ALU_DIV, ALU_REM});
    abs_a = sa_in ? -a : a;
    abs_b = sb_in ? -b : b;

    // Sign-extend per op; the low 64 bits of the product are then correct mod 2^64.
    a64       = {{32{a[31] && (op inside {ALU_MULH, ALU_MULHSU})}}, a};
    b64       = {{32{b[31] && (op == ALU_MULH)}}, b};
    prod_comb = a64 * b64;

    if (div_zero)      fast_result = is_rem ? a : 32'hFFFF_FFFF;
    else if (div_ovf)  fast_result = is_rem ? 32'h0 : 32'h8000_0000;
    else if (op == ALU_MUL) fast_result = prod_comb[31:0];
    else               fast_result = prod_comb[63:32];
  end

  // One iteration step of each algorithm
  logic [32:0] mul_sum;
  logic [63:0] mul_next, div_next;
  logic        div_ge;
  logic [31:0] div_sub;
  logic        step_is_mul;

  always_comb begin
    step_is_mul = op_q inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    mul_sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next    = {mul_sum, acc_q[31:1]};
    // Shifted remainder is acc_q[63:31]; it is always < 2*divisor, so 33 bits suffice.
    div_ge      = acc_q[63:31] >= {1'b0, opnd_q};
    div_sub     = acc_q[62:31] - opnd_q;
    div_next    = div_ge ? {div_sub, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
  end

  // Sign fix-up of the finished magnitude result
  logic [63:0] prod_fix;
  logic [31:0] done_result;

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    case (op_q)
      ALU_MUL:                          done_result = prod_fix[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  done_result = prod_fix[63:32];
      ALU_DIV:  done_result = (neg_a_q ^ neg_b_q) ? -acc_q[31:0] : acc_q[31:0];
      ALU_DIVU: done_result = acc_q[31:0];
      ALU_REM:  done_result = neg_a_q ? -acc_q[63:32] : acc_q[63:32];
      ALU_REMU: done_result = acc_q[63:32];
      default:  done_result = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= MDU_IDLE;
      count_q <= 6'd0;
      acc_q   <= 64'h0;
      opnd_q  <= 32'h0;
      op_q    <= ALU_MUL;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    busy    = 1'b0;
    done    = 1'b0;
    result  = fast_result;

    case (state_q)
      MDU_IDLE: begin
        if (start && !flush) begin
          if (fast) begin
            done = 1'b1;
          end else begin
            busy    = 1'b1;
            state_d = MDU_BUSY;
            count_d = 6'd0;
            op_d    = op;
            neg_a_d = sa_in;
            neg_b_d = sb_in;
            if (is_mul) begin
              acc_d  = {32'h0, abs_b};
              opnd_d = abs_a;
            end else begin
              acc_d  = {32'h0, abs_a};
              opnd_d = abs_b;
            end
          end
        end
      end
      MDU_BUSY: begin
        busy    = !flush;
        acc_d   = step_is_mul ? mul_next : div_next;
        count_d = count_q + 6'd1;
        if (count_q == 6'(STEPS - 1)) state_d = MDU_DONE;
      end
      MDU_DONE: begin
        done    = !flush;
        result  = done_result;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase

    if (flush) state_d = MDU_IDLE;
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: 1-cycle ALU, iterative MDU, EX/MEM pipeline register.
// Latency: 1 edge for ALU/load/store/fast-path M ops, 34 edges for iterative M ops.
// Backpressure: exStall (combinational) holds ID/EX while an M op iterates; stalled edges write bubbles.
// Ports: clk, arstn, bus (ex_stage_if.slave: EXControl, flush in; MEControl, exStall out).
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter bit MDU_ITERATIVE_MUL = 1'b1,
  parameter int MDU_STEPS         = 32    // tied to XLEN; leave at 32
) (
  input logic       clk,
  input logic       arstn,
  ex_stage_if.slave bus
);

  localparam MEStageSignals ME_RESET = '{
    aluResult:           32'h0,
    loadSignal:          1'b0,
    storeSignal:         1'b0,
    loadStoreByteSelect: FUNCT3_BYTE,
    storeData:           32'h0,
    rdAddr:              5'd0,
    rdWriteEn:           1'b0,
    destinationSelect:   WB_SEL_ALU,
    pc:                  32'h0
  };

  EXStageSignals ex;
  MEStageSignals me_q, me_d;
  logic [31:0]   alu_out, result, mdu_result;
  logic [4:0]    shamt;
  logic          mdu_op, mdu_busy, mdu_done, ex_stall;

  assign ex     = bus.EXControl;
  assign shamt  = ex.operandB[4:0];
  assign mdu_op = is_mdu_op(ex.aluControl);

  always_comb begin
    alu_out = 32'h0;
    if (ex.loadSignal || ex.storeSignal) begin
      alu_out = ex.operandA + ex.operandB;   // effective address
    end else begin
      case (ex.aluControl)
        ALU_ADD:    alu_out = ex.operandA + ex.operandB;
        ALU_SUB:    alu_out = ex.operandA - ex.operandB;
        ALU_SLL:    alu_out = ex.operandA << shamt;
        ALU_SLT:    alu_out = {31'd0, $signed(ex.operandA) < $signed(ex.operandB)};
        ALU_SLTU:   alu_out = {31'd0, ex.operandA < ex.operandB};
        ALU_XOR:    alu_out = ex.operandA ^ ex.operandB;
        ALU_SRL:    alu_out = ex.operandA >> shamt;
        ALU_SRA:    alu_out = $unsigned($signed(ex.operandA) >>> shamt);
        ALU_OR:     alu_out = ex.operandA | ex.operandB;
        ALU_AND:    alu_out = ex.operandA & ex.operandB;
        ALU_PASS_B: alu_out = ex.operandB;
        default:    alu_out = 32'h0;
      endcase
    end
  end

  ex_stage_mdu_iterative #(
    .ITERATIVE_MUL (MDU_ITERATIVE_MUL),
    .STEPS         (MDU_STEPS)
  ) u_mdu_iterative (
    .clk    (clk),
    .arstn  (arstn),
    .start  (mdu_op),
    .op     (ex.aluControl),
    .a      (ex.operandA),
    .b      (ex.operandB),
    .flush  (bus.flush),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .result (mdu_result)
  );

  // Keep stall low while reset is held, whatever ID/EX happens to contain.
  assign ex_stall = mdu_busy && arstn;
  assign result   = (mdu_op && mdu_done) ? mdu_result : alu_out;

  always_comb begin
    me_d.aluResult           = result;
    me_d.loadSignal          = ex.loadSignal;
    me_d.storeSignal         = ex.storeSignal;
    me_d.loadStoreByteSelect = ex.loadStoreByteSelect;
    me_d.storeData           = ex.storeData;
    me_d.rdAddr              = ex.rdAddr;
    me_d.rdWriteEn           = ex.rdWriteEn;
    me_d.destinationSelect   = ex.destinationSelect;
    me_d.pc                  = ex.pc;
  end

  // Bubbles only clear the side-effect bits; the rest of the register holds.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      me_q <= ME_RESET;
    end else if (bus.flush || ex_stall) begin
      me_q.rdWriteEn   <= 1'b0;
      me_q.loadSignal  <= 1'b0;
      me_q.storeSignal <= 1'b0;
    end else begin
      me_q <= me_d;
    end
  end

  assign bus.MEControl = me_q;
  assign bus.exStall   = ex_stall;

endmodule
